// File: rtl/switch_pkg.sv
// Shared switch types: node ids, routing LUT entries, flits and the config-writer register map.
// Used by switch_cfg_writer (optional empty-entry skipping: SWITCH_CFG_SKIP_EMPTY_EN).
package switch_pkg;

    localparam int NUM_OUTPORTS  = 4;
    localparam int TOTAL_NODES   = 4;
    localparam int TABLE_SIZE    = 8;
    localparam int NODE_ID_W     = $clog2(TOTAL_NODES);
    localparam int PORT_W        = $clog2(NUM_OUTPORTS);
    localparam int FLITS_PER_RUN = TABLE_SIZE + 1;
    localparam int FLIT_CNT_W    = $clog2(TABLE_SIZE + 2);

    typedef logic [NODE_ID_W-1:0] node_id_t;

    typedef struct packed {
        logic [1:0]        vc_mask;
        logic [PORT_W-1:0] port;
    } route_lut_t;

    typedef enum logic [1:0] {
        FLIT_DATA      = 2'd0,
        FLIT_CFG_WRITE = 2'd1,
        FLIT_CFG_READ  = 2'd2
    } flit_type_t;

    typedef logic [7:0] cfg_addr_t;
    typedef logic [7:0] cfg_data_t;

    typedef struct packed {
        cfg_addr_t addr;
        cfg_data_t data;
    } cfg_payload_t;

    typedef struct packed {
        node_id_t     dest;
        node_id_t     src;
        flit_type_t   ftype;
        cfg_payload_t payload;
    } flit_t;

    localparam cfg_addr_t CFG_ADDR_DATELINE = 8'd0;
    localparam cfg_addr_t CFG_ADDR_LUT_BASE = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        DATELINE,
        LUT,
        DONE
    } cfg_writer_state_t;

    function automatic cfg_data_t zext_dateline(input logic [NUM_OUTPORTS-1:0] mask);
        cfg_data_t d;
        d = '0;
        d[NUM_OUTPORTS-1:0] = mask;
        return d;
    endfunction

    function automatic cfg_data_t zext_lut(input route_lut_t entry);
        cfg_data_t d;
        d = '0;
        d[$bits(route_lut_t)-1:0] = entry;
        return d;
    endfunction

    function automatic flit_t build_cfg_flit(input node_id_t dest, input node_id_t src,
                                             input cfg_addr_t addr, input cfg_data_t data);
        flit_t f;
        f.dest         = dest;
        f.src          = src;
        f.ftype        = FLIT_CFG_WRITE;
        f.payload.addr = addr;
        f.payload.data = data;
        return f;
    endfunction

endpackage

// File: rtl/switch_cfg_writer.sv
// Serialises a snapshot of the dateline mask and routing LUT into config-write flits.
// Define SWITCH_CFG_SKIP_EMPTY_EN to skip all-zero LUT entries instead of writing them.
module switch_cfg_writer
    import switch_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  node_id_t                          dest_id,
    input  node_id_t                          src_id,
    input  logic [NUM_OUTPORTS-1:0]           dateline_in,
    input  route_lut_t [TABLE_SIZE-1:0]       route_lut_in,
    output flit_t                             out_flit,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done,
    output logic [FLIT_CNT_W-1:0]             flits_sent
);

`ifdef SWITCH_CFG_SKIP_EMPTY_EN
    localparam bit SKIP_EMPTY = 1'b1;
`else
    localparam bit SKIP_EMPTY = 1'b0;
`endif

    localparam int                IDX_W    = $clog2(TABLE_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TABLE_SIZE - 1);

    cfg_writer_state_t            state_q, state_d;
    logic [IDX_W-1:0]             index_q, index_d, next_idx;
    flit_t                        flit_q, flit_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [FLIT_CNT_W-1:0]        cnt_q, cnt_d;

    node_id_t                     dest_q, src_q;
    logic [NUM_OUTPORTS-1:0]      dateline_q;
    route_lut_t [TABLE_SIZE-1:0]  lut_q;

    logic accept, handshake, advance;

    assign accept    = (state_q == IDLE) && start;
    assign handshake = valid_q && out_ready;
    // A stalled flit waits for ready; an empty skipped slot (valid low) always moves on.
    assign advance   = valid_q ? out_ready : 1'b1;

    // Lookahead so trailing empty entries end the run right after the last real write.
    function automatic logic any_nonempty_from(input route_lut_t [TABLE_SIZE-1:0] lut,
                                               input int first);
        logic found;
        found = 1'b0;
        for (int j = 0; j < TABLE_SIZE; j++) begin
            if (j >= first && lut[j] != '0) found = 1'b1;
        end
        return found;
    endfunction

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        next_idx = '0;
        flit_d   = flit_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        if (handshake && cnt_q != FLIT_CNT_W'(FLITS_PER_RUN)) cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATELINE;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    // The snapshot is not loaded yet, so the first flit comes from the live inputs.
                    flit_d  = build_cfg_flit(dest_id, src_id, CFG_ADDR_DATELINE,
                                             zext_dateline(dateline_in));
                end
            end
            DATELINE: begin
                if (handshake) begin
                    index_d = '0;
                    if (!SKIP_EMPTY || any_nonempty_from(lut_q, 0)) begin
                        state_d = LUT;
                        valid_d = !SKIP_EMPTY || (lut_q[0] != '0);
                        flit_d  = build_cfg_flit(dest_q, src_q, CFG_ADDR_LUT_BASE,
                                                 zext_lut(lut_q[0]));
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end
                end
            end
            LUT: begin
                if (advance) begin
                    if (index_q == LAST_IDX ||
                        (SKIP_EMPTY && !any_nonempty_from(lut_q, int'(index_q) + 1))) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        next_idx = index_q + 1'b1;
                        index_d  = next_idx;
                        valid_d  = !SKIP_EMPTY || (lut_q[next_idx] != '0);
                        flit_d   = build_cfg_flit(dest_q, src_q,
                                                  CFG_ADDR_LUT_BASE + cfg_addr_t'(next_idx),
                                                  zext_lut(lut_q[next_idx]));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            flit_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the snapshot bank has no reset; it is always written on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            dest_q     <= dest_id;
            src_q      <= src_id;
            dateline_q <= dateline_in;
            lut_q      <= route_lut_in;
        end
    end

    // The dateline snapshot is only consumed via the live-input first flit; keep it for debug visibility.
    logic dateline_unused;
    assign dateline_unused = ^dateline_q;

    assign out_flit   = flit_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign flits_sent = cnt_q;

endmodule

// File: tb/tb_switch_cfg_writer.sv
// Directed bench for switch_cfg_writer: scenario table plus reset and skip-empty sequences.
module tb_switch_cfg_writer;
    import switch_pkg::*;

    logic                         clk;
    logic                         rst;
    logic                         start;
    node_id_t                     dest_id, src_id;
    logic [NUM_OUTPORTS-1:0]      dateline_in;
    route_lut_t [TABLE_SIZE-1:0]  route_lut_in;
    flit_t                        out_flit;
    logic                         out_valid;
    logic                         out_ready;
    logic                         busy;
    logic                         done;
    logic [FLIT_CNT_W-1:0]        flits_sent;

    switch_cfg_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dest_id      (dest_id),
        .src_id       (src_id),
        .dateline_in  (dateline_in),
        .route_lut_in (route_lut_in),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .flits_sent   (flits_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          ready_mode;    // 0: always ready, 1: ready pattern 1,0,0 repeating
        int          inject_at;     // cycle at which a stray start is pulsed, -1 for none
        int          exp_done_cyc;
        node_id_t    dest;
        node_id_t    src;
        logic [3:0]  dateline;
    } scen_t;

    flit_t cap[$];
    int    done_cnt, done_cyc, first_valid_cyc, stall_err, valid_after_done;
    logic  busy_at_first;

    // Drives one run starting at a negedge and records everything the DUT emits.
    task automatic run_once(input node_id_t d, input node_id_t s, input logic [3:0] dl,
                            input route_lut_t [TABLE_SIZE-1:0] lut,
                            input int ready_mode, input int inject_at);
        flit_t prev_flit;
        logic  prev_valid, prev_ready;
        int    post;
        cap.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_err = 0; valid_after_done = 0; busy_at_first = 1'b0;
        dest_id = d; src_id = s; dateline_in = dl; route_lut_in = lut; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Changing inputs after the accepted start must not leak into the run.
        dest_id = ~d; src_id = ~s; dateline_in = ~dl; route_lut_in = ~lut;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_flit = '0; post = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            start = (cyc == inject_at);
            if (start) dateline_in = 4'b1111;
            if (cyc == 0) busy_at_first = busy;
            if (prev_valid && !prev_ready && (!out_valid || out_flit !== prev_flit)) stall_err++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cnt > 0 && out_valid) valid_after_done++;
            if (out_valid && out_ready) cap.push_back(out_flit);
            prev_valid = out_valid; prev_ready = out_ready; prev_flit = out_flit;
            if (done_cyc >= 0) begin
                post++;
                if (post > 3) break;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("run_terminated", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_flits(input string tag, input node_id_t d, input node_id_t s,
                               input int exp_addr[$], input int exp_data[$]);
        check($sformatf("%s_flit_count", tag), 32'(cap.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < cap.size(); i++) begin
            check($sformatf("%s_dest[%0d]", tag, i),  32'(cap[i].dest), 32'(d));
            check($sformatf("%s_src[%0d]", tag, i),   32'(cap[i].src), 32'(s));
            check($sformatf("%s_type[%0d]", tag, i),  32'(cap[i].ftype), 32'd1);
            check($sformatf("%s_addr[%0d]", tag, i),  32'(cap[i].payload.addr), 32'(exp_addr[i]));
            check($sformatf("%s_data[%0d]", tag, i),  32'(cap[i].payload.data), 32'(exp_data[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        scen_t                        scen [4];
        route_lut_t [TABLE_SIZE-1:0]  lut;
        int                           exp_addr[$], exp_data[$];
        int                           bad;

        scen[0] = '{"ready_const", 0, -1, 10, node_id_t'(2), node_id_t'(1), 4'b0101};
        scen[1] = '{"ready_toggle", 1, -1, 26, node_id_t'(3), node_id_t'(0), 4'b0101};
        scen[2] = '{"start_busy",  0,  3, 10, node_id_t'(1), node_id_t'(2), 4'b0101};
        scen[3] = '{"start_done",  0,  9, 10, node_id_t'(0), node_id_t'(3), 4'b0101};

        for (int i = 0; i < TABLE_SIZE; i++) lut[i] = route_lut_t'(4'(i + 1));

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        dest_id = '0; src_id = '0; dateline_in = '0; route_lut_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        check("reset_count", 32'(flits_sent), 32'd0);
        check("reset_flit",  32'(out_flit), 32'd0);

        bad = 0;
        out_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy || done || flits_sent != 0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        for (int s = 0; s < 4; s++) begin
            run_once(scen[s].dest, scen[s].src, scen[s].dateline, lut,
                     scen[s].ready_mode, scen[s].inject_at);
            check({scen[s].name, "_busy_first"},  32'(busy_at_first), 32'd1);
            check({scen[s].name, "_first_valid"}, 32'(first_valid_cyc), 32'd0);
            check({scen[s].name, "_done_cycle"},  32'(done_cyc), 32'(scen[s].exp_done_cyc));
            check({scen[s].name, "_done_pulses"}, 32'(done_cnt), 32'd1);
            check({scen[s].name, "_stall_hold"},  32'(stall_err), 32'd0);
            check({scen[s].name, "_idle_after"},  32'(valid_after_done), 32'd0);
            check({scen[s].name, "_flits_sent"},  32'(flits_sent), 32'd9);
            check({scen[s].name, "_busy_end"},    32'(busy), 32'd0);
            exp_addr.delete(); exp_data.delete();
            exp_addr.push_back(0); exp_data.push_back(5);
            for (int i = 0; i < TABLE_SIZE; i++) begin
                exp_addr.push_back(i + 1);
                exp_data.push_back(i + 1);
            end
            check_flits(scen[s].name, scen[s].dest, scen[s].src, exp_addr, exp_data);
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a run, right after the 4th handshake.
        dest_id = node_id_t'(2); src_id = node_id_t'(1); dateline_in = 4'b0101;
        route_lut_in = lut; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_count_before", 32'(flits_sent), 32'd4);
        check("midrst_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_count", 32'(flits_sent), 32'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || busy || done) bad++;
        end
        check("midrst_no_continue", 32'(bad), 32'd0);
        run_once(node_id_t'(2), node_id_t'(1), 4'b0101, lut, 0, -1);
        check("restart_done_cycle", 32'(done_cyc), 32'd10);
        check("restart_flits_sent", 32'(flits_sent), 32'd9);
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(0); exp_data.push_back(5);
        for (int i = 0; i < TABLE_SIZE; i++) begin
            exp_addr.push_back(i + 1);
            exp_data.push_back(i + 1);
        end
        check_flits("restart", node_id_t'(2), node_id_t'(1), exp_addr, exp_data);

`ifdef SWITCH_CFG_SKIP_EMPTY_EN
        repeat (2) @(negedge clk);
        lut[2] = '0; lut[5] = '0; lut[7] = '0;
        run_once(node_id_t'(3), node_id_t'(2), 4'b0101, lut, 0, -1);
        check("skip_done_cycle", 32'(done_cyc), 32'd9);
        check("skip_done_pulses", 32'(done_cnt), 32'd1);
        check("skip_flits_sent", 32'(flits_sent), 32'd6);
        exp_addr = '{0, 1, 2, 4, 5, 7};
        exp_data = '{5, 1, 2, 4, 5, 7};
        check_flits("skip", node_id_t'(3), node_id_t'(2), exp_addr, exp_data);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
